// File: rtl/snn_interfaces_pkg.sv
// Shared types for the spike-event link between the capture and convolution stages.
package snn_interfaces_pkg;

  localparam int VEC_COORD_W = 8;

  typedef struct packed {
    logic [VEC_COORD_W-1:0] x;
    logic [VEC_COORD_W-1:0] y;
  } vec2_t;

  localparam logic [1:0] CAP_IDLE     = 2'd0;
  localparam logic [1:0] CAP_FETCH    = 2'd1;
  localparam logic [1:0] CAP_PRESENT  = 2'd2;
  localparam logic [1:0] CAP_WAIT_ACK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = CAP_IDLE,
    ST_FETCH    = CAP_FETCH,
    ST_PRESENT  = CAP_PRESENT,
    ST_WAIT_ACK = CAP_WAIT_ACK
  } capture_state_t;

  // Raw word layout: x in the upper half, y in the lower half.
  function automatic vec2_t unpack_raw_event(input logic [2*VEC_COORD_W-1:0] raw);
    vec2_t v;
    v.x = raw[2*VEC_COORD_W-1:VEC_COORD_W];
    v.y = raw[VEC_COORD_W-1:0];
    return v;
  endfunction

endpackage

// File: rtl/snn_event_if.sv
// Producer/consumer handshake carrying one decoded spike coordinate.
interface snn_event_if;
  snn_interfaces_pkg::vec2_t event_coord;
  logic                      event_valid;
  logic                      event_ready;
  logic                      event_ack;

  modport capture (output event_coord, output event_valid,
                   input  event_ready, input  event_ack);
  modport conv    (input  event_coord, input  event_valid,
                   output event_ready, output event_ack);
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear takes priority over an increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/snn_event_capture.sv
// Pops raw spike words, bounds-checks them and hands in-range coordinates to the
// convolution stage with a valid/ready transfer followed by an ack (with timeout).
module snn_event_capture
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int RAW_W       = 2 * COORD_W,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int CNT_W       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [RAW_W-1:0] fifo_data,
  snn_event_if.capture     event_if,
  input  logic             stats_clr,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             timeout_err
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]    TO_LIMIT = TO_W'(ACK_TIMEOUT);
  localparam logic [COORD_W:0]   X_LIM    = (COORD_W + 1)'(IMG_WIDTH);
  localparam logic [COORD_W:0]   Y_LIM    = (COORD_W + 1)'(IMG_HEIGHT);

  capture_state_t  state_q, state_d;
  vec2_t           coord_q, coord_d;
  logic            valid_q, valid_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            sent_inc;
  logic            drop_inc;
  logic            rd_en;

  vec2_t raw_coord;
  logic  in_bounds;

  assign raw_coord = unpack_raw_event(fifo_data);
  assign in_bounds = ({1'b0, raw_coord.x} < X_LIM) && ({1'b0, raw_coord.y} < Y_LIM);

  always_comb begin
    state_d   = state_q;
    coord_d   = coord_q;
    valid_d   = valid_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    sent_inc  = 1'b0;
    drop_inc  = 1'b0;
    rd_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          rd_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (in_bounds) begin
          coord_d = raw_coord;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      // valid_q is always high here, so ready alone marks the transfer.
      ST_PRESENT: begin
        if (event_if.event_ready) begin
          valid_d = 1'b0;
          if (event_if.event_ack) begin
            sent_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (event_if.event_ack) begin
          sent_inc = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stats_clr) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      coord_q   <= '0;
      valid_q   <= 1'b0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      coord_q   <= coord_d;
      valid_q   <= valid_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_sent_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sent_inc),
    .clr   (stats_clr),
    .q     (sent_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .clr   (stats_clr),
    .q     (drop_count)
  );

  assign fifo_rd_en           = rd_en;
  assign busy                 = (state_q != ST_IDLE);
  assign timeout_err          = timeout_q;
  assign event_if.event_coord = coord_q;
  assign event_if.event_valid = valid_q;

endmodule

// File: tb/tb_snn_event_capture.sv
// Randomized scoreboard bench for snn_event_capture with a FIFO model and a
// consumer that randomizes ready and the ack delay after each transfer.
module tb_snn_event_capture;
  import snn_interfaces_pkg::*;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int CNT_W  = 4;
  localparam int ACK_TO = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             stats_clr = 1'b0;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             busy;
  logic             timeout_err;
  logic [15:0]      fifo_data = '0;
  logic [CNT_W-1:0] sent_count;
  logic [CNT_W-1:0] drop_count;

  snn_event_if ev_if ();

  snn_event_capture #(
    .COORD_W(8), .RAW_W(16), .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H),
    .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .event_if(ev_if),
    .stats_clr(stats_clr), .busy(busy), .sent_count(sent_count),
    .drop_count(drop_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int rd_cyc = 0;
  bit rd_seen = 1'b0;
  logic [15:0] fifo_mem [0:1023];
  logic [15:0] exp_mem [0:1023];
  int exp_wr = 0;
  int exp_rd = 0;
  int exp_sent = 0;
  int exp_drop = 0;
  int exp_to = 0;
  int ready_mode = 1;  // 0 random, 1 always, 2 never
  int ack_mode = 0;    // <0 random delay, else fixed delay after transfer

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[pop_cnt[9:0]];
      pop_cnt   <= pop_cnt + 1;
      rd_cyc    <= cyc;
      rd_seen   <= 1'b1;
    end
  end

  function automatic bit oob(logic [15:0] w);
    return (int'(w[15:8]) >= IMG_W) || (int'(w[7:0]) >= IMG_H);
  endfunction

  function automatic int sat_inc(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic void chk(string nm, int act, int req);
    vec_cnt++;
    if (act != req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  task automatic push_word(logic [15:0] w);
    fifo_mem[push_cnt[9:0]] = w;
    if (!oob(w)) begin
      exp_mem[exp_wr[9:0]] = w;
      exp_wr++;
    end
    push_cnt++;
  endtask

  task automatic wait_valid(string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ev_if.event_valid && n < 100);
    chk({nm, "_valid_seen"}, int'(ev_if.event_valid), 1);
  endtask

  task automatic quiesce(string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(fifo_empty && !busy && exp_rd == exp_wr) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, int'(n < 5000), 1);
    repeat (10) @(negedge clk);
  endtask

  // Consumer + monitor: drives ready/ack, pops the scoreboard on each transfer,
  // and keeps the expected counter values.
  initial begin : monitor
    int c, d, ack_at, sent_at, to_at, rel_at;
    bit in_flight, prev_hold, check_low, inc_drop, rdy;
    logic [15:0] prev_coord, cur;
    ack_at = -1; sent_at = -1; to_at = -1; rel_at = -1; d = 0;
    in_flight = 0; prev_hold = 0; check_low = 0; prev_coord = '0;
    ev_if.event_ready = 1'b0;
    ev_if.event_ack   = 1'b0;
    forever begin
      @(negedge clk);
      c = cyc;
      inc_drop = 0;
      cur = ev_if.event_coord;
      if (fifo_rd_en) chk("rd_en_gate", int'(enable && !fifo_empty), 1);
      if (rd_seen && c == rd_cyc + 1 && oob(fifo_data)) inc_drop = 1;
      if (rd_seen && c == rd_cyc + 2) begin
        if (oob(fifo_data)) begin
          chk("drop_back_idle", int'(busy), 0);
          chk("drop_no_valid", int'(ev_if.event_valid), 0);
        end else begin
          chk("latency_valid", int'(ev_if.event_valid), 1);
          chk("latency_coord", int'(cur), int'(fifo_data));
        end
      end
      if (prev_hold) begin
        chk("hold_valid", int'(ev_if.event_valid), 1);
        chk("hold_coord", int'(cur), int'(prev_coord));
      end
      if (check_low) chk("valid_after_xfer", int'(ev_if.event_valid), 0);
      if (in_flight) begin
        if (c == rel_at) begin
          chk("release_idle", int'(busy), 0);
          in_flight = 0;
        end else begin
          chk("busy_in_flight", int'(busy), 1);
        end
      end

      rdy = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      ev_if.event_ack = (c == ack_at);
      check_low = 0;
      prev_hold = 0;
      if (ev_if.event_valid && rdy) begin
        chk("event_expected", int'(exp_rd != exp_wr), 1);
        if (exp_rd != exp_wr) begin
          chk("event_coord", int'(cur), int'(exp_mem[exp_rd[9:0]]));
          exp_rd++;
        end
        d = (ack_mode >= 0) ? ack_mode :
            (($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 6)));
        ack_at  = c + d;
        if (d == 0) ev_if.event_ack = 1'b1;
        sent_at = (d <= ACK_TO) ? c + d : -1;
        to_at   = (d > ACK_TO) ? c + ACK_TO : -1;
        rel_at  = (d <= ACK_TO) ? c + d + 1 : c + ACK_TO + 1;
        in_flight = 1;
        check_low = 1;
        $display("xfer %0d: coord=(%0d,%0d) ack_delay=%0d", exp_rd, cur[15:8], cur[7:0], d);
      end else if (ev_if.event_valid) begin
        prev_hold  = 1;
        prev_coord = cur;
      end
      ev_if.event_ready = rdy;

      @(posedge clk);
      if (stats_clr) begin
        exp_sent = 0;
        exp_drop = 0;
        exp_to   = 0;
      end else begin
        if (c == sent_at) exp_sent = sat_inc(exp_sent);
        if (inc_drop) exp_drop = sat_inc(exp_drop);
        if (c == to_at) exp_to = 1;
      end
    end
  end

  task automatic check_counters(string nm);
    chk({nm, "_sent"}, int'(sent_count), exp_sent);
    chk({nm, "_drop"}, int'(drop_count), exp_drop);
    chk({nm, "_timeout"}, int'(timeout_err), exp_to);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
  endtask

  initial begin : main
    int base;
    logic [7:0] x, y;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", int'(ev_if.event_valid), 0);
    chk("reset_coord", int'(ev_if.event_coord), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_en", int'(fifo_rd_en), 0);
    chk("reset_sent", int'(sent_count), 0);
    chk("reset_drop", int'(drop_count), 0);
    chk("reset_timeout", int'(timeout_err), 0);

    // Single in-bounds event, ready and ack together.
    @(posedge clk); #1;
    enable = 1'b1; ready_mode = 1; ack_mode = 0;
    push_word(16'h0507);
    quiesce("basic");
    chk("basic_sent_abs", int'(sent_count), 1);
    check_counters("basic");

    // Out-of-bounds x is dropped.
    @(posedge clk); #1;
    push_word(16'h2003);
    quiesce("drop");
    chk("drop_count_abs", int'(drop_count), 1);
    check_counters("drop");

    // Back-pressure for 10 cycles, then ack 3 cycles after transfer.
    @(posedge clk); #1;
    ready_mode = 2; ack_mode = 3;
    push_word(16'h0A1F);
    wait_valid("hold");
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    ready_mode = 1;
    quiesce("hold");
    chk("hold_sent_abs", int'(sent_count), 2);
    chk("one_rd_per_word", pop_cnt, 3);
    check_counters("hold");

    // Ack never arrives in time, then a normal event still goes through.
    @(posedge clk); #1;
    ack_mode = 6;
    push_word(16'h1111);
    quiesce("timeout");
    chk("timeout_err_abs", int'(timeout_err), 1);
    chk("timeout_sent_abs", int'(sent_count), 2);
    @(posedge clk); #1;
    ack_mode = 0;
    push_word(16'h1E1E);
    quiesce("after_to");
    chk("after_to_sent_abs", int'(sent_count), 3);
    check_counters("after_to");

    pulse_clear();
    @(negedge clk);
    check_counters("clear");
    chk("clear_timeout_abs", int'(timeout_err), 0);

    // Enable dropped while an event is presented with words queued.
    @(posedge clk); #1;
    ready_mode = 2; ack_mode = 0;
    base = pop_cnt;
    push_word(16'h0102); push_word(16'h0304); push_word(16'h0506);
    wait_valid("enable");
    @(posedge clk); #1;
    enable = 1'b0; ready_mode = 1;
    repeat (20) @(negedge clk);
    chk("enable_blocks_reads", pop_cnt - base, 1);
    chk("enable_idle", int'(busy), 0);
    @(posedge clk); #1;
    enable = 1'b1;
    quiesce("enable");
    chk("enable_all_read", pop_cnt - base, 3);
    check_counters("enable");

    // Randomized traffic.
    @(posedge clk); #1;
    ready_mode = 0; ack_mode = -1;
    for (int i = 0; i < 200; i++) begin
      x = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      y = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      push_word({x, y});
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    quiesce("random");
    check_counters("random");

    // Saturation of the sent counter, then clear racing an ack.
    pulse_clear();
    @(posedge clk); #1;
    ready_mode = 1; ack_mode = 0;
    for (int i = 0; i < SAT + 2; i++) push_word({8'(i), 8'(31 - i)});
    quiesce("sat");
    chk("sat_sent_abs", int'(sent_count), SAT);
    check_counters("sat");
    @(posedge clk); #1;
    push_word(16'h0808);
    wait_valid("clr_ack");
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    quiesce("clr_ack");
    chk("clr_ack_sent_abs", int'(sent_count), 0);
    check_counters("clr_ack");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
